// File: rtl/rv_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rv_bus_pkg
//  Purpose  : Shared main-bus definitions: arbiter state encoding, default
//             Wishbone widths and a bundled Wishbone request type.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package rv_bus_pkg;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic                   cyc;
    logic                   stb;
    logic                   we;
    logic [WB_ADDR_W-1:0]   adr;
    logic [WB_DATA_W-1:0]   dat;
    logic [WB_DATA_W/8-1:0] sel;
  } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/wb_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : wb_rr_pick
//  Purpose  : Combinational round-robin picker. Selects the first asserted
//             request at or above ptr, wrapping modulo N.
//  Ports    : req   in  N      request vector
//             ptr   in  PTR_W  starting index (must be < N)
//             grant out N      one-hot winner (zero when nothing requested)
//             valid out 1      a winner exists
//  Revision : 1.0  initial release
// ============================================================================
module wb_rr_pick #(
  parameter int N     = 2,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic             valid
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  // Walk the requests starting at ptr; the first hit wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(N)) sum = sum - (PTR_W+1)'(N);
      idx = sum[PTR_W-1:0];
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_master_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_master_arbiter
//  Purpose  : Round-robin Wishbone master arbiter with per-transfer timeout.
//             Grants one master for its whole CYC burst and forces a one-cycle
//             error pulse when the slave stalls STB for TIMEOUT_CYCLES.
//  Ports    : i_clk, i_reset          clock / sync active-high reset
//             i_m_*                   per-master Wishbone requests (flattened)
//             o_m_dat/o_m_ack/o_m_err responses (ack/err to owner only)
//             o_grant                 one-hot owner, zero when idle
//             o_s_*, i_s_dat, i_s_ack slave-side Wishbone
//  Revision : 1.0  initial release
// ============================================================================
module wb_master_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                  i_clk,
  input  logic                                  i_reset,
  input  logic [NUM_MASTERS-1:0]                i_m_cyc,
  input  logic [NUM_MASTERS-1:0]                i_m_stb,
  input  logic [NUM_MASTERS-1:0]                i_m_we,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     i_m_adr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     i_m_dat,
  input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0] i_m_sel,
  output logic [DATA_WIDTH-1:0]                 o_m_dat,
  output logic [NUM_MASTERS-1:0]                o_m_ack,
  output logic [NUM_MASTERS-1:0]                o_m_err,
  output logic [NUM_MASTERS-1:0]                o_grant,
  output logic                                  o_s_cyc,
  output logic                                  o_s_stb,
  output logic                                  o_s_we,
  output logic [ADDR_WIDTH-1:0]                 o_s_adr,
  output logic [DATA_WIDTH-1:0]                 o_s_dat,
  output logic [DATA_WIDTH/8-1:0]               o_s_sel,
  input  logic [DATA_WIDTH-1:0]                 i_s_dat,
  input  logic                                  i_s_ack
);

  import rv_bus_pkg::*;

  localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SEL_W = DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t             state;
  logic [PTR_W-1:0]       owner;
  logic [PTR_W-1:0]       rr_ptr;
  logic [PTR_W-1:0]       next_ptr;
  logic [PTR_W-1:0]       pick_ptr;
  logic [PTR_W-1:0]       win_idx;
  logic [CNT_W-1:0]       tmo_cnt;
  logic [NUM_MASTERS-1:0] pick_req;
  logic [NUM_MASTERS-1:0] win;
  logic                   win_valid;
  logic                   busy;
  logic                   owner_cyc;
  logic                   owner_stb;
  logic                   release_now;
  logic                   ack_now;
  logic                   err_now;

  assign busy        = (state == ARB_BUSY);
  assign owner_cyc   = i_m_cyc[owner];
  assign owner_stb   = i_m_stb[owner];
  assign release_now = busy && !owner_cyc;
  assign next_ptr    = (owner == PTR_W'(NUM_MASTERS - 1)) ? '0 : owner + 1'b1;

  // A slave ACK in the limit cycle beats the timeout.
  assign ack_now = busy && owner_stb && i_s_ack;
  assign err_now = busy && owner_stb && !i_s_ack && (tmo_cnt == TMO_LAST);

  // On release the departing owner is excluded so a waiter takes over
  // at the same edge, searching from the slot after the old owner.
  assign pick_req = busy ? (i_m_cyc & ~o_grant) : i_m_cyc;
  assign pick_ptr = busy ? next_ptr : rr_ptr;

  wb_rr_pick #(
    .N     (NUM_MASTERS),
    .PTR_W (PTR_W)
  ) u_pick (
    .req   (pick_req),
    .ptr   (pick_ptr),
    .grant (win),
    .valid (win_valid)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (win[i]) win_idx = PTR_W'(i);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= ARB_IDLE;
      o_grant <= '0;
      owner   <= '0;
      rr_ptr  <= '0;
      tmo_cnt <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          tmo_cnt <= '0;
          if (win_valid) begin
            state   <= ARB_BUSY;
            o_grant <= win;
            owner   <= win_idx;
          end
        end
        ARB_BUSY: begin
          if (release_now) begin
            rr_ptr  <= next_ptr;
            tmo_cnt <= '0;
            if (win_valid) begin
              o_grant <= win;
              owner   <= win_idx;
            end else begin
              state   <= ARB_IDLE;
              o_grant <= '0;
            end
          end else if (ack_now || err_now || !owner_stb) begin
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Slave side follows the owner combinationally while busy.
  assign o_s_cyc = busy && owner_cyc;
  assign o_s_stb = busy && owner_stb && !err_now;
  assign o_s_we  = busy && i_m_we[owner];
  assign o_s_adr = busy ? i_m_adr[owner*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign o_s_dat = busy ? i_m_dat[owner*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign o_s_sel = busy ? i_m_sel[owner*SEL_W +: SEL_W] : '0;

  // Responses are suppressed while reset is held so an aborted access
  // never sees a late ACK or ERR.
  assign o_m_dat = busy ? i_s_dat : '0;
  assign o_m_ack = o_grant & {NUM_MASTERS{ack_now && !i_reset}};
  assign o_m_err = o_grant & {NUM_MASTERS{err_now && !i_reset}};

endmodule
`default_nettype wire

// File: tb/tb_wb_master_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_master_arbiter
//  Purpose  : Directed self-checking bench for wb_master_arbiter
//             (2 masters, TIMEOUT_CYCLES = 8).
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_wb_master_arbiter;

  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              i_clk = 1'b0;
  logic              i_reset;
  logic [NM-1:0]     i_m_cyc, i_m_stb, i_m_we;
  logic [NM*AW-1:0]  i_m_adr;
  logic [NM*DW-1:0]  i_m_dat;
  logic [NM*4-1:0]   i_m_sel;
  logic [DW-1:0]     o_m_dat;
  logic [NM-1:0]     o_m_ack, o_m_err, o_grant;
  logic              o_s_cyc, o_s_stb, o_s_we;
  logic [AW-1:0]     o_s_adr;
  logic [DW-1:0]     o_s_dat;
  logic [3:0]        o_s_sel;
  logic [DW-1:0]     i_s_dat;
  logic              i_s_ack;

  int n_checks = 0;
  int n_fail   = 0;

  wb_master_arbiter #(
    .NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_m_cyc(i_m_cyc), .i_m_stb(i_m_stb), .i_m_we(i_m_we),
    .i_m_adr(i_m_adr), .i_m_dat(i_m_dat), .i_m_sel(i_m_sel),
    .o_m_dat(o_m_dat), .o_m_ack(o_m_ack), .o_m_err(o_m_err), .o_grant(o_grant),
    .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb), .o_s_we(o_s_we),
    .o_s_adr(o_s_adr), .o_s_dat(o_s_dat), .o_s_sel(o_s_sel),
    .i_s_dat(i_s_dat), .i_s_ack(i_s_ack)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_m_cyc = '0; i_m_stb = '0; i_m_we = '0;
    i_m_adr = '0; i_m_dat = '0; i_m_sel = '0;
    i_s_dat = '0; i_s_ack = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    i_reset = 1'b1;
    tick(); tick();
    i_reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tick(); tick(); tick();
    @(negedge i_clk);
    n_checks++; if (o_grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant got %b exp 00", o_grant); end
    n_checks++; if (o_s_cyc !== 1'b0) begin n_fail++; $display("FAIL reset_s_cyc got %b exp 0", o_s_cyc); end
    n_checks++; if (o_m_ack !== 2'b00) begin n_fail++; $display("FAIL reset_ack got %b exp 00", o_m_ack); end
    n_checks++; if (o_m_err !== 2'b00) begin n_fail++; $display("FAIL reset_err got %b exp 00", o_m_err); end
  endtask

  task automatic test_single();
    do_reset();
    i_m_cyc[0] = 1'b1; i_m_stb[0] = 1'b1; i_m_we[0] = 1'b1;
    i_m_adr[31:0] = 32'h1000_0004; i_m_dat[31:0] = 32'h55; i_m_sel[3:0] = 4'hF;
    @(negedge i_clk);
    n_checks++; if (o_s_cyc !== 1'b0) begin n_fail++; $display("FAIL single_latency got %b exp 0", o_s_cyc); end
    tick();
    @(negedge i_clk);
    n_checks++; if (o_s_cyc !== 1'b1) begin n_fail++; $display("FAIL single_s_cyc got %b exp 1", o_s_cyc); end
    n_checks++; if (o_grant !== 2'b01) begin n_fail++; $display("FAIL single_grant got %b exp 01", o_grant); end
    n_checks++; if (o_s_adr !== 32'h1000_0004) begin n_fail++; $display("FAIL single_adr got %h exp 10000004", o_s_adr); end
    n_checks++; if (o_s_dat !== 32'h55) begin n_fail++; $display("FAIL single_dat got %h exp 00000055", o_s_dat); end
    n_checks++; if ({o_s_we, o_s_sel} !== 5'b1_1111) begin n_fail++; $display("FAIL single_we_sel got %b exp 11111", {o_s_we, o_s_sel}); end
    n_checks++; if (o_m_ack !== 2'b00) begin n_fail++; $display("FAIL single_noack got %b exp 00", o_m_ack); end
    tick();
    i_s_ack = 1'b1; i_s_dat = 32'hCAFE_F00D;
    @(negedge i_clk);
    n_checks++; if (o_m_ack !== 2'b01) begin n_fail++; $display("FAIL single_ack got %b exp 01", o_m_ack); end
    n_checks++; if (o_m_dat !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL single_rdata got %h exp cafef00d", o_m_dat); end
    tick();
    clear_inputs();
    tick();
    @(negedge i_clk);
    n_checks++; if (o_grant !== 2'b00) begin n_fail++; $display("FAIL single_release got %b exp 00", o_grant); end
  endtask

  task automatic test_round_robin();
    do_reset();
    i_m_cyc = 2'b11; i_m_stb = 2'b11;
    i_m_adr = {32'h0000_00B0, 32'h0000_00A0};
    tick();
    @(negedge i_clk);
    n_checks++; if (o_grant !== 2'b01) begin n_fail++; $display("FAIL rr_first got %b exp 01", o_grant); end
    n_checks++; if (o_s_adr !== 32'hA0) begin n_fail++; $display("FAIL rr_first_adr got %h exp a0", o_s_adr); end
    tick();
    i_m_cyc[0] = 1'b0; i_m_stb[0] = 1'b0;
    @(negedge i_clk);
    n_checks++; if (o_s_cyc !== 1'b0) begin n_fail++; $display("FAIL rr_drop_cyc got %b exp 0", o_s_cyc); end
    tick();
    @(negedge i_clk);
    n_checks++; if (o_grant !== 2'b10) begin n_fail++; $display("FAIL rr_handover got %b exp 10", o_grant); end
    n_checks++; if ({o_s_cyc, o_s_adr} !== {1'b1, 32'hB0}) begin n_fail++; $display("FAIL rr_handover_bus got %b/%h exp 1/b0", o_s_cyc, o_s_adr); end
    tick();
    i_m_cyc = 2'b00; i_m_stb = 2'b00;
    tick();
    i_m_cyc = 2'b11; i_m_stb = 2'b11;
    tick();
    @(negedge i_clk);
    n_checks++; if (o_grant !== 2'b01) begin n_fail++; $display("FAIL rr_second_round got %b exp 01", o_grant); end
    clear_inputs();
    tick(); tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    i_m_cyc[1] = 1'b1; i_m_stb[1] = 1'b1;
    tick();
    i_m_cyc[0] = 1'b1; i_m_stb[0] = 1'b1;
    for (int b = 0; b < 3; b++) begin
      i_s_ack = 1'b1;
      @(negedge i_clk);
      n_checks++; if (o_grant !== 2'b10) begin n_fail++; $display("FAIL burst_grant beat %0d got %b exp 10", b, o_grant); end
      n_checks++; if (o_m_ack !== 2'b10) begin n_fail++; $display("FAIL burst_ack beat %0d got %b exp 10", b, o_m_ack); end
      tick();
    end
    i_s_ack = 1'b0;
    i_m_cyc[1] = 1'b0; i_m_stb[1] = 1'b0;
    @(negedge i_clk);
    n_checks++; if (o_grant !== 2'b10) begin n_fail++; $display("FAIL burst_hold got %b exp 10", o_grant); end
    tick();
    @(negedge i_clk);
    n_checks++; if (o_grant !== 2'b01) begin n_fail++; $display("FAIL burst_switch got %b exp 01", o_grant); end
    clear_inputs();
    tick(); tick();
  endtask

  task automatic test_timeout();
    int errs;
    errs = 0;
    do_reset();
    i_m_cyc[0] = 1'b1; i_m_stb[0] = 1'b1;
    tick();
    // Busy cycle k: the 8th and 16th stalled cycles hit the limit; the 16th
    // carries an ACK, which must win over the error.
    for (int k = 1; k <= 16; k++) begin
      i_s_ack = (k == 16);
      @(negedge i_clk);
      if (o_m_err != 2'b00) errs++;
      if (k == 7 || k == 9) begin
        n_checks++; if ({o_m_err, o_s_stb} !== 3'b00_1) begin n_fail++; $display("FAIL tmo_quiet k=%0d got err %b stb %b exp 00/1", k, o_m_err, o_s_stb); end
      end
      if (k == 8) begin
        n_checks++; if (o_m_err !== 2'b01) begin n_fail++; $display("FAIL tmo_err got %b exp 01", o_m_err); end
        n_checks++; if (o_s_stb !== 1'b0) begin n_fail++; $display("FAIL tmo_stb got %b exp 0", o_s_stb); end
        n_checks++; if (o_m_ack !== 2'b00) begin n_fail++; $display("FAIL tmo_ack got %b exp 00", o_m_ack); end
      end
      if (k == 16) begin
        n_checks++; if ({o_m_ack, o_m_err} !== 4'b01_00) begin n_fail++; $display("FAIL tmo_ack_wins got ack %b err %b exp 01/00", o_m_ack, o_m_err); end
      end
      tick();
    end
    n_checks++; if (errs != 1) begin n_fail++; $display("FAIL tmo_err_count got %0d exp 1", errs); end
    @(negedge i_clk);
    n_checks++; if (o_grant !== 2'b01) begin n_fail++; $display("FAIL tmo_grant_kept got %b exp 01", o_grant); end
    clear_inputs();
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    i_m_cyc = 2'b11; i_m_stb = 2'b11;
    tick();
    i_reset = 1'b1; i_s_ack = 1'b1;
    @(negedge i_clk);
    n_checks++; if (o_m_ack !== 2'b00) begin n_fail++; $display("FAIL rstmid_ack got %b exp 00", o_m_ack); end
    tick();
    @(negedge i_clk);
    n_checks++; if (o_grant !== 2'b00) begin n_fail++; $display("FAIL rstmid_grant got %b exp 00", o_grant); end
    n_checks++; if ({o_s_cyc, o_s_stb, o_m_ack, o_m_err} !== 6'b0) begin n_fail++; $display("FAIL rstmid_quiet got %b exp 000000", {o_s_cyc, o_s_stb, o_m_ack, o_m_err}); end
    i_reset = 1'b0; i_s_ack = 1'b0;
    i_m_cyc = 2'b10; i_m_stb = 2'b10;
    tick();
    @(negedge i_clk);
    n_checks++; if ({o_grant, o_s_cyc} !== 3'b10_1) begin n_fail++; $display("FAIL rstmid_regrant got %b/%b exp 10/1", o_grant, o_s_cyc); end
    clear_inputs();
    tick();
  endtask

  initial begin
    i_reset = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
